id_ex_skid_reg: RTL and testbench
=================================

// Module: id_ex_skid_reg
// PURPOSE
//  ID->EX pipeline boundary directly downstream of the opcode decoder.
//  Registers decoded control bundles (ex/mem/wb), operands and PC into EX.
//  2-entry skid buffer (main + skid) gives registered in_ready and full throughput.
//  Undecodable opcodes are neutered to a side-effect-free bubble; the first one's PC is logged.
// PARAMETERS
//  XLEN    32  datapath / PC width
//  RADDR_W 5   register-address width
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  flush          in   1       kill all held entries (branch taken / redirect)
//  in_valid       in   1       ID presents an instruction
//  in_ready       out  1       stage can accept (registered)
//  in_ex_control  in   7       {alu_in1_sel[2],alu_in2_sel[2],alu_op[2],branch}
//  in_mem_control in   2       {mem_read,mem_write}
//  in_wb_control  in   2       {mem_data_select,reg_write}
//  in_unrecognized in  1       decoder flagged opcode as illegal
//  in_pc,in_rs1_data,in_rs2_data,in_imm  in  XLEN each  operands
//  in_rd          in   RADDR_W destination register
//  in_funct3      in   3       funct3 field
//  in_funct7b5    in   1       instr[30]
//  out_valid      out  1       EX holds a valid instruction
//  out_ready      in   1       EX consumes this cycle
//  out_* (ex_control,mem_control,wb_control,pc,rs1_data,rs2_data,imm,rd,funct3,funct7b5)
//                 out  as in_  main-entry fields
//  out_illegal    out  1       main entry came from an unrecognized opcode
//  illegal_seen   out  1       sticky: an illegal instruction left the stage
//  illegal_pc     out  XLEN    PC of first such instruction
// BEHAVIOUR
//  Reset: main_valid=skid_valid=0, in_ready=1, all out_* =0, illegal_seen=0, illegal_pc=0.
//  accept = in_valid & in_ready; drain = out_valid & out_ready. out_valid = main_valid.
//  Latency: accept at cycle N with stage empty -> out_valid at N+1.
//  Transfers per cycle (no flush):
//   - main empty or drain, skid empty: accepted entry -> main.
//   - main held (no drain), accept: entry -> skid; in_ready=0 from next cycle.
//   - drain with skid valid: skid -> main, skid cleared; in_ready=1 next cycle.
//   - in_ready is never high while skid_valid=1, so accept+skid-full cannot occur.
//  Strict FIFO order; no entry dropped or duplicated except by flush.
//  Flush (priority over all): main_valid,skid_valid <=0; an accept in the
//   same cycle is discarded; in_ready=1 next cycle. drain in flush cycle still
//   counts as delivered (EX already sampled it).
//  Illegal neutering at capture: if in_unrecognized=1, store mem_control=2'b00,
//   wb_control=2'b00, ex_control=7'b0, illegal=1; pc/rd kept for trap reporting.
//  Bubble gating: when main_valid=0, out_mem_control, out_wb_control,
//   out_ex_control[0] and out_illegal read 0 (data fields don't-care).
//  Log: on drain with out_illegal=1 and illegal_seen=0 -> illegal_seen<=1,
//   illegal_pc<=out_pc. Later illegals ignored; cleared only by rst.
//  Reset mid-operation: rst overrides flush and handshakes; both entries lost.
//  Control widths pass through unmodified; no arithmetic on data.
// TESTING
//  1 Reset, in_valid=1 R-type ex=7'b1000100, wb=2'b01, out_ready=1 -> next cycle
//    out_valid=1, same fields; 10 back-to-back -> 10 outputs in order, in_ready stays 1.
//  2 out_ready=0, send pc=0x100,0x104 -> in_ready=0 after 2nd; release out_ready
//    -> 0x100 then 0x104 on consecutive cycles, in_ready returns 1.
//  3 Stage full (2 entries), flush=1 with in_valid=1 pc=0x200 -> next cycle
//    out_valid=0, in_ready=1; 0x200 never appears at output.
//  4 in_unrecognized=1 pc=0x40, mem=2'b01, wb=2'b11 -> out_illegal=1, out_mem=0,
//    out_wb=0; after drain illegal_seen=1, illegal_pc=0x40; second illegal
//    pc=0x80 leaves illegal_pc=0x40.
//  5 Idle cycles -> out_mem_control=0, out_wb_control=0, out_ex_control[0]=0.
//  6 rst asserted while full and out_ready=0 -> next cycle out_valid=0,
//    in_ready=1, illegal_seen=0.

Source files
------------

// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// ID->EX pipeline boundary placed directly after the opcode decoder. It
// registers the decoded control bundles (ex/mem/wb), the operands and the PC
// into EX. Two entries (main + skid) let in_ready be driven from a flop while
// still sustaining one instruction per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: accept = in_valid & in_ready. Downstream:
// drain = out_valid & out_ready. A valid producer holds its payload stable
// until the transfer. in_ready depends only on state and never on in_valid.
//
// Instructions flagged as unrecognized are turned into a side-effect-free
// bubble when captured, with illegal=1. The PC of the first one that leaves
// the stage is logged in illegal_pc, and illegal_seen goes high.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              kill all held entries; an accept in the same cycle
//                      is discarded
//   in_valid/in_ready  upstream handshake (in_ready is registered)
//   in_*               decoded instruction from ID
//   out_valid/out_ready downstream handshake (out_valid = main entry valid)
//   out_*              fields of the main entry
//   out_illegal        main entry came from an unrecognized opcode
//   illegal_seen       sticky flag: an illegal instruction left the stage
//   illegal_pc         PC of the first such instruction
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_ex_control,
    input  logic [1:0]         in_mem_control,
    input  logic [1:0]         in_wb_control,
    input  logic               in_unrecognized,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [2:0]         in_funct3,
    input  logic               in_funct7b5,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         out_ex_control,
    output logic [1:0]         out_mem_control,
    output logic [1:0]         out_wb_control,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [RADDR_W-1:0] out_rd,
    output logic [2:0]         out_funct3,
    output logic               out_funct7b5,
    output logic               out_illegal,

    output logic               illegal_seen,
    output logic [XLEN-1:0]    illegal_pc
);

    typedef struct packed {
        logic [6:0]         ex;
        logic [1:0]         mem;
        logic [1:0]         wb;
        logic               illegal;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rd;
        logic [2:0]         funct3;
        logic               funct7b5;
    } entry_t;

    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              illegal_seen_q, illegal_seen_d;
    logic [XLEN-1:0]   illegal_pc_q, illegal_pc_d;

    entry_t            cap;
    logic              accept;
    logic              drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = main_valid_q & out_ready;

    // Capture image of the incoming instruction. An unrecognized opcode keeps
    // pc/rd (and the operands) for trap reporting but loses every control bit
    // that could cause a side effect.
    always_comb begin
        cap.ex       = in_ex_control;
        cap.mem      = in_mem_control;
        cap.wb       = in_wb_control;
        cap.illegal  = 1'b0;
        cap.pc       = in_pc;
        cap.rs1      = in_rs1_data;
        cap.rs2      = in_rs2_data;
        cap.imm      = in_imm;
        cap.rd       = in_rd;
        cap.funct3   = in_funct3;
        cap.funct7b5 = in_funct7b5;
        if (in_unrecognized) begin
            cap.ex      = 7'b0;
            cap.mem     = 2'b00;
            cap.wb      = 2'b00;
            cap.illegal = 1'b1;
        end
    end

    always_comb begin
        main_d         = main_q;
        skid_d         = skid_q;
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        illegal_seen_d = illegal_seen_q;
        illegal_pc_d   = illegal_pc_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain || !main_valid_q) begin
            // Main slot frees this cycle: the older skid entry goes first to
            // keep FIFO order. in_ready is low whenever skid is full, so an
            // accept cannot coincide with a skid refill.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = cap;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = cap;
            skid_valid_d = 1'b1;
        end

        // The instruction draining in a flush cycle has already been sampled
        // by EX, so it still counts for the log.
        if (drain && main_q.illegal && !illegal_seen_q) begin
            illegal_seen_d = 1'b1;
            illegal_pc_d   = main_q.pc;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q         <= '0;
            skid_q         <= '0;
            main_valid_q   <= 1'b0;
            skid_valid_q   <= 1'b0;
            in_ready_q     <= 1'b1;
            illegal_seen_q <= 1'b0;
            illegal_pc_q   <= '0;
        end else begin
            main_q         <= main_d;
            skid_q         <= skid_d;
            main_valid_q   <= main_valid_d;
            skid_valid_q   <= skid_valid_d;
            in_ready_q     <= in_ready_d;
            illegal_seen_q <= illegal_seen_d;
            illegal_pc_q   <= illegal_pc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;

    // Side-effect carrying bits read 0 when no instruction is held so EX
    // never acts on a stale entry.
    assign out_ex_control  = {main_q.ex[6:1], main_q.ex[0] & main_valid_q};
    assign out_mem_control = main_valid_q ? main_q.mem : 2'b00;
    assign out_wb_control  = main_valid_q ? main_q.wb  : 2'b00;
    assign out_illegal     = main_valid_q & main_q.illegal;

    assign out_pc       = main_q.pc;
    assign out_rs1_data = main_q.rs1;
    assign out_rs2_data = main_q.rs2;
    assign out_imm      = main_q.imm;
    assign out_rd       = main_q.rd;
    assign out_funct3   = main_q.funct3;
    assign out_funct7b5 = main_q.funct7b5;

    assign illegal_seen = illegal_seen_q;
    assign illegal_pc   = illegal_pc_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
module tb_id_ex_skid_reg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int EW      = 7 + 2 + 2 + 1 + 4 * XLEN + RADDR_W + 3 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [6:0]         in_ex_control = '0;
    logic [1:0]         in_mem_control = '0;
    logic [1:0]         in_wb_control = '0;
    logic               in_unrecognized = 1'b0;
    logic [XLEN-1:0]    in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic [RADDR_W-1:0] in_rd = '0;
    logic [2:0]         in_funct3 = '0;
    logic               in_funct7b5 = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [6:0]         out_ex_control;
    logic [1:0]         out_mem_control, out_wb_control;
    logic [XLEN-1:0]    out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [RADDR_W-1:0] out_rd;
    logic [2:0]         out_funct3;
    logic               out_funct7b5, out_illegal, illegal_seen;
    logic [XLEN-1:0]    illegal_pc;

    id_ex_skid_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ex_control(in_ex_control), .in_mem_control(in_mem_control),
        .in_wb_control(in_wb_control), .in_unrecognized(in_unrecognized),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_rd(in_rd), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ex_control(out_ex_control), .out_mem_control(out_mem_control),
        .out_wb_control(out_wb_control), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_illegal(out_illegal), .illegal_seen(illegal_seen), .illegal_pc(illegal_pc)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] model_in();
        if (in_unrecognized)
            return {7'b0, 2'b00, 2'b00, 1'b1, in_pc, in_rs1_data, in_rs2_data, in_imm,
                    in_rd, in_funct3, in_funct7b5};
        return {in_ex_control, in_mem_control, in_wb_control, 1'b0, in_pc, in_rs1_data,
                in_rs2_data, in_imm, in_rd, in_funct3, in_funct7b5};
    endfunction

    logic [EW-1:0] out_bundle;
    assign out_bundle = {out_ex_control, out_mem_control, out_wb_control, out_illegal, out_pc,
                         out_rs1_data, out_rs2_data, out_imm, out_rd, out_funct3, out_funct7b5};

    // Inputs change 1 time unit after posedge, so the negedge sees the values
    // that the next posedge will act on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_drain", 1, 0);
                else check("drain", out_bundle, exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model_in());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [XLEN-1:0] pc, input logic [6:0] ex,
                             input logic [1:0] mem, input logic [1:0] wb, input logic bad);
        in_pc           = pc;
        in_ex_control   = ex;
        in_mem_control  = mem;
        in_wb_control   = wb;
        in_unrecognized = bad;
        in_rs1_data     = $urandom;
        in_rs2_data     = $urandom;
        in_imm          = $urandom;
        in_rd           = RADDR_W'($urandom_range(0, 31));
        in_funct3       = 3'($urandom_range(0, 7));
        in_funct7b5     = 1'($urandom_range(0, 1));
    endtask

    // Present one instruction and hold it until accepted (bounded).
    task automatic send(input logic [XLEN-1:0] pc, input logic [6:0] ex,
                        input logic [1:0] mem, input logic [1:0] wb, input logic bad);
        bit done = 0;
        set_instr(pc, ex, mem, wb, bad);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready;
            tick();
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid        = 1'b0;
        in_unrecognized = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("queue_empty", EW'(exp_q.size()), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) tick();
        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_mem", out_mem_control, 0);
        check("rst_out_wb", out_wb_control, 0);
        check("rst_illegal_seen", illegal_seen, 0);
        check("rst_illegal_pc", illegal_pc, 0);
        rst = 1'b0;
        tick();

        // 1: single R-type, one-cycle latency, then 10 back-to-back
        out_ready = 1'b1;
        send(32'h1000, 7'b1000100, 2'b00, 2'b01, 1'b0);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_ex", out_ex_control, 7'b1000100);
        check("t1_out_wb", out_wb_control, 2'b01);
        for (int i = 0; i < 10; i++) begin
            check("t1_in_ready", in_ready, 1);
            if (i == 9) send(32'h2000 + 4 * i, 7'b0000001, 2'b10, 2'b11, 1'b0);
            else        send(32'h2000 + 4 * i, 7'($urandom_range(0, 127)), 2'b01, 2'b01, 1'b0);
        end
        idle();
        check("t1_in_ready_end", in_ready, 1);
        wait_empty();

        // 5: idle gating, last entry had branch/mem/wb bits set
        tick();
        check("t5_out_valid", out_valid, 0);
        check("t5_out_mem", out_mem_control, 0);
        check("t5_out_wb", out_wb_control, 0);
        check("t5_out_ex0", out_ex_control[0], 0);
        check("t5_out_illegal", out_illegal, 0);

        // 2: backpressure fills skid, then releases in order
        out_ready = 1'b0;
        send(32'h100, 7'b0000100, 2'b00, 2'b01, 1'b0);
        check("t2_in_ready_1", in_ready, 1);
        send(32'h104, 7'b0000100, 2'b00, 2'b01, 1'b0);
        idle();
        check("t2_in_ready_full", in_ready, 0);
        check("t2_out_pc0", out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        check("t2_out_pc1", out_pc, 32'h104);
        check("t2_in_ready_back", in_ready, 1);
        tick();
        check("t2_out_valid_done", out_valid, 0);

        // 3: flush while full, with an accept attempt
        out_ready = 1'b0;
        send(32'h300, 7'b0, 2'b01, 2'b01, 1'b0);
        send(32'h304, 7'b0, 2'b01, 2'b01, 1'b0);
        set_instr(32'h200, 7'b0, 2'b01, 2'b01, 1'b0);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("t3_out_valid", out_valid, 0);
        check("t3_in_ready", in_ready, 1);
        // flush with in_ready high and one entry held: accept is discarded
        send(32'h308, 7'b0, 2'b01, 2'b01, 1'b0);
        set_instr(32'h204, 7'b0, 2'b01, 2'b01, 1'b0);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("t3b_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("t3_no_ghost", out_valid, 0);

        // 4: illegal neutering and log
        out_ready = 1'b0;
        send(32'h40, 7'b1111111, 2'b01, 2'b11, 1'b1);
        idle();
        check("t4_out_illegal", out_illegal, 1);
        check("t4_out_mem", out_mem_control, 0);
        check("t4_out_wb", out_wb_control, 0);
        check("t4_seen_before", illegal_seen, 0);
        out_ready = 1'b1;
        tick();
        check("t4_seen", illegal_seen, 1);
        check("t4_pc", illegal_pc, 32'h40);
        send(32'h80, 7'b0, 2'b10, 2'b01, 1'b1);
        idle();
        repeat (2) tick();
        check("t4_pc_kept", illegal_pc, 32'h40);

        // random traffic with flushes
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            set_instr($urandom, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 29) == 0);
            tick();
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        wait_empty();
        check("rand_pc_kept", illegal_pc, 32'h40);

        // 6: reset while full and stalled
        out_ready = 1'b0;
        send(32'h500, 7'b0, 2'b01, 2'b01, 1'b0);
        send(32'h504, 7'b0, 2'b01, 2'b01, 1'b0);
        idle();
        check("t6_full", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_out_valid", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_illegal_seen", illegal_seen, 0);
        check("t6_illegal_pc", illegal_pc, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("t6_no_ghost", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
